pc_seq_ctrl: RTL and testbench

- Control FSM that sequences the 9-bit program-counter/2-level-stack register of the structural PIC core.
- Takes decoded instruction-class information from the decoder and drives the PC register's load/push/pop/write/out-enable strobes and its data/address inputs.
- Inserts pipeline flush cycles after control transfers, implements SLEEP, and tracks stack depth.

---
 rtl/pc_seq_ctrl_if.sv | 34 +++
 rtl/pc_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - decoder/PC-register signal bundle for the PC sequencing controller
interface pc_seq_ctrl_if;
    logic       instr_valid;
    logic [2:0] op_class;
    logic [8:0] target;
    logic       skip_cond;
    logic [7:0] wr_data;
    logic       wake;
    logic [8:0] pc_cur;
    logic       pc_load;
    logic       pc_push;
    logic       pc_pop;
    logic       pc_write_en;
    logic       pc_out_en;
    logic [8:0] pc_addr_in;
    logic [7:0] pc_data_in;
    logic       flush;
    logic       sleeping;
    logic [1:0] stack_depth;
    logic       stk_ovf;
    logic       stk_unf;

    modport master (
        input  instr_valid, op_class, target, skip_cond, wr_data, wake, pc_cur,
        output pc_load, pc_push, pc_pop, pc_write_en, pc_out_en, pc_addr_in, pc_data_in,
        output flush, sleeping, stack_depth, stk_ovf, stk_unf
    );

    modport slave (
        output instr_valid, op_class, target, skip_cond, wr_data, wake, pc_cur,
        input  pc_load, pc_push, pc_pop, pc_write_en, pc_out_en, pc_addr_in, pc_data_in,
        input  flush, sleeping, stack_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC/stack sequencing FSM (RUN/FLUSH/SLEEP); STACK_GUARD_EN traps stack faults
module pc_seq_ctrl #(
    parameter int         STACK_DEPTH = 2,
    parameter logic [8:0] TRAP_VECTOR = 9'h1FF
) (
    input  logic          clock,
    input  logic          reset,
    pc_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_SLEEP} state_t;

    localparam logic [2:0] OP_GOTO   = 3'd1;
    localparam logic [2:0] OP_CALL   = 3'd2;
    localparam logic [2:0] OP_RETURN = 3'd3;
    localparam logic [2:0] OP_SKIP   = 3'd4;
    localparam logic [2:0] OP_SLEEP  = 3'd5;
    localparam logic [2:0] OP_WRPCL  = 3'd6;
    localparam logic [2:0] OP_RDPCL  = 3'd7;
    localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

    state_t     state, state_nxt;
    logic [1:0] depth, depth_nxt;
    logic       ovf, unf, ovf_set, unf_set;
    logic       load, push, pop, wr_en, out_en, flush, sleeping;
    logic [8:0] addr;
    logic [7:0] data;

`ifndef STACK_GUARD_EN
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            depth <= 2'd0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
            ovf   <= ovf | ovf_set;
            unf   <= unf | unf_set;
        end
    end

    // A hold is expressed as a load of the current PC, since the register increments by default.
    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        load      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        wr_en     = 1'b0;
        out_en    = 1'b0;
        flush     = 1'b0;
        sleeping  = 1'b0;
        addr      = bus.pc_cur;
        data      = 8'h00;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (!bus.instr_valid) begin
                        load = 1'b1;
                    end else begin
                        case (bus.op_class)
                            OP_GOTO: begin
                                load      = 1'b1;
                                addr      = bus.target;
                                state_nxt = ST_FLUSH;
                            end
                            OP_CALL: begin
                                state_nxt = ST_FLUSH;
                                if (depth == DEPTH_MAX) begin
                                    ovf_set = 1'b1;
`ifdef STACK_GUARD_EN
                                    load = 1'b1;
                                    addr = TRAP_VECTOR;
`else
                                    push = 1'b1;
                                    data = bus.target[7:0];
`endif
                                end else begin
                                    push      = 1'b1;
                                    data      = bus.target[7:0];
                                    depth_nxt = depth + 2'd1;
                                end
                            end
                            OP_RETURN: begin
                                state_nxt = ST_FLUSH;
                                if (depth == 2'd0) begin
                                    unf_set = 1'b1;
`ifdef STACK_GUARD_EN
                                    load = 1'b1;
                                    addr = TRAP_VECTOR;
`else
                                    pop = 1'b1;
`endif
                                end else begin
                                    pop       = 1'b1;
                                    depth_nxt = depth - 2'd1;
                                end
                            end
                            OP_SKIP: begin
                                if (bus.skip_cond) state_nxt = ST_FLUSH;
                            end
                            OP_SLEEP: begin
                                load      = 1'b1;
                                state_nxt = ST_SLEEP;
                            end
                            OP_WRPCL: begin
                                wr_en     = 1'b1;
                                data      = bus.wr_data;
                                state_nxt = ST_FLUSH;
                            end
                            OP_RDPCL: out_en = 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_FLUSH: begin
                    flush     = 1'b1;
                    state_nxt = ST_RUN;
                end
                ST_SLEEP: begin
                    sleeping = 1'b1;
                    load     = 1'b1;
                    if (bus.wake) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign bus.pc_load     = load;
    assign bus.pc_push     = push;
    assign bus.pc_pop      = pop;
    assign bus.pc_write_en = wr_en;
    assign bus.pc_out_en   = out_en;
    assign bus.pc_addr_in  = addr;
    assign bus.pc_data_in  = data;
    assign bus.flush       = flush;
    assign bus.sleeping    = sleeping;
    assign bus.stack_depth = depth;
    assign bus.stk_ovf     = ovf;
    assign bus.stk_unf     = unf;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed scoreboard bench for pc_seq_ctrl with a behavioural PC/stack register
module tb_pc_seq_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_seq_ctrl_if bus ();
    pc_seq_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // PC register with 2-level stack: write_en > push > pop > load > increment
    logic [8:0] pc;
    logic [8:0] stk [2];
    always @(posedge clock) begin
        if (reset) begin
            pc <= 9'h000;
        end else if (bus.pc_write_en) begin
            pc <= {pc[8], bus.pc_data_in};
        end else if (bus.pc_push) begin
            stk[1] <= stk[0];
            stk[0] <= pc + 9'd1;
            pc     <= {1'b0, bus.pc_data_in};
        end else if (bus.pc_pop) begin
            pc     <= stk[0];
            stk[0] <= stk[1];
        end else if (bus.pc_load) begin
            pc <= bus.pc_addr_in;
        end else begin
            pc <= pc + 9'd1;
        end
    end
    assign bus.pc_cur = pc;

    localparam logic [4:0] N = 5'b00000, L = 5'b10000, PU = 5'b01000, PO = 5'b00100, W = 5'b00010, O = 5'b00001;

    typedef struct {
        logic [4:0] strb;
        logic [8:0] addr;
        logic [7:0] data;
        logic       fl;
        logic       sl;
        logic [1:0] dep;
        logic       ovf;
        logic       unf;
        logic       chk_pc;
        logic [8:0] pc;
    } exp_t;

    exp_t sb [$];

    function automatic exp_t mk(logic [4:0] strb, logic [8:0] addr, logic [7:0] data, logic fl, logic sl,
                                logic [1:0] dep, logic ovf, logic unf, logic chk_pc, logic [8:0] pcv);
        exp_t e;
        e.strb = strb; e.addr = addr; e.data = data; e.fl = fl; e.sl = sl;
        e.dep = dep; e.ovf = ovf; e.unf = unf; e.chk_pc = chk_pc; e.pc = pcv;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        logic [4:0] strb;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            strb = {bus.pc_load, bus.pc_push, bus.pc_pop, bus.pc_write_en, bus.pc_out_en};
            chk({tag, ".strobes"}, 16'(strb), 16'(e.strb));
            chk({tag, ".flush"}, 16'(bus.flush), 16'(e.fl));
            chk({tag, ".sleeping"}, 16'(bus.sleeping), 16'(e.sl));
            chk({tag, ".depth"}, 16'(bus.stack_depth), 16'(e.dep));
            chk({tag, ".ovf"}, 16'(bus.stk_ovf), 16'(e.ovf));
            chk({tag, ".unf"}, 16'(bus.stk_unf), 16'(e.unf));
            if (e.strb[4]) chk({tag, ".addr"}, 16'(bus.pc_addr_in), 16'(e.addr));
            if (e.strb[3] || e.strb[1]) chk({tag, ".data"}, 16'(bus.pc_data_in), 16'(e.data));
            if (e.chk_pc) chk({tag, ".pc"}, 16'(bus.pc_cur), 16'(e.pc));
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic v, input logic [2:0] op,
                        input logic [8:0] tg, input logic sc, input logic [7:0] wd, input logic wk, input exp_t e);
        reset = rst; bus.instr_valid = v; bus.op_class = op; bus.target = tg;
        bus.skip_cond = sc; bus.wr_data = wd; bus.wake = wk;
        sb.push_back(e);
        @(negedge clock);
        compare(tag);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; bus.instr_valid = 1'b0; bus.op_class = 3'd0; bus.target = 9'h0;
        bus.skip_cond = 1'b0; bus.wr_data = 8'h0; bus.wake = 1'b0;
        @(posedge clock); #1;
        step("reset",   1, 0, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h000));
        step("seq0",    0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h000));
        step("seq1",    0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h001));
        step("seq2",    0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h002));
        step("goto",    0, 1, 3'd1, 9'h123, 0, 8'h00, 0, mk(L, 9'h123, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h003));
        step("goto_fl", 0, 1, 3'd1, 9'h055, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 0, 0, 1, 9'h123));
        step("idle",    0, 0, 3'd0, 9'h000, 0, 8'h00, 0, mk(L, 9'h124, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h124));
        step("call1",   0, 1, 3'd2, 9'h040, 0, 8'h00, 0, mk(PU, 9'h000, 8'h40, 0, 0, 2'd0, 0, 0, 1, 9'h124));
        step("call1_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd1, 0, 0, 1, 9'h040));
        step("call2",   0, 1, 3'd2, 9'h050, 0, 8'h00, 0, mk(PU, 9'h000, 8'h50, 0, 0, 2'd1, 0, 0, 1, 9'h041));
        step("call2_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd2, 0, 0, 1, 9'h050));
`ifdef STACK_GUARD_EN
        step("call3",   0, 1, 3'd2, 9'h060, 0, 8'h00, 0, mk(L, 9'h1FF, 8'h00, 0, 0, 2'd2, 0, 0, 1, 9'h051));
        step("call3_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd2, 1, 0, 1, 9'h1FF));
`else
        step("call3",   0, 1, 3'd2, 9'h060, 0, 8'h00, 0, mk(PU, 9'h000, 8'h60, 0, 0, 2'd2, 0, 0, 1, 9'h051));
        step("call3_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd2, 1, 0, 1, 9'h060));
`endif
        step("ret1",    0, 1, 3'd3, 9'h000, 0, 8'h00, 0, mk(PO, 9'h000, 8'h00, 0, 0, 2'd2, 1, 0, 0, 9'h000));
        step("ret1_fl", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd1, 1, 0, 0, 9'h000));
        step("ret2",    0, 1, 3'd3, 9'h000, 0, 8'h00, 0, mk(PO, 9'h000, 8'h00, 0, 0, 2'd1, 1, 0, 0, 9'h000));
        step("ret2_fl", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 1, 0, 0, 9'h000));
`ifdef STACK_GUARD_EN
        step("ret3",    0, 1, 3'd3, 9'h000, 0, 8'h00, 0, mk(L, 9'h1FF, 8'h00, 0, 0, 2'd0, 1, 0, 0, 9'h000));
        step("ret3_fl", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 1, 1, 1, 9'h1FF));
`else
        step("ret3",    0, 1, 3'd3, 9'h000, 0, 8'h00, 0, mk(PO, 9'h000, 8'h00, 0, 0, 2'd0, 1, 0, 0, 9'h000));
        step("ret3_fl", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 1, 1, 0, 9'h000));
`endif
        step("rst_flg", 1, 1, 3'd2, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 1, 1, 0, 9'h000));
        step("flg_clr", 0, 0, 3'd0, 9'h000, 0, 8'h00, 0, mk(L, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h000));
        step("goto_0f", 0, 1, 3'd1, 9'h00F, 0, 8'h00, 0, mk(L, 9'h00F, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h000));
        step("goto_0ff",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 0, 0, 1, 9'h00F));
        step("skip1",   0, 1, 3'd4, 9'h000, 1, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h010));
        step("skip1_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 0, 0, 1, 9'h011));
        step("skip1_pc",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h012));
        step("skip0",   0, 1, 3'd4, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h013));
        step("skip0_nf",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h014));
        step("rdpcl",   0, 1, 3'd7, 9'h000, 0, 8'h00, 0, mk(O, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h015));
        step("wrpcl",   0, 1, 3'd6, 9'h000, 0, 8'h1C, 0, mk(W, 9'h000, 8'h1C, 0, 0, 2'd0, 0, 0, 1, 9'h016));
        step("wrpcl_fl",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 0, 0, 1, 9'h01C));
        step("goto_1f", 0, 1, 3'd1, 9'h01F, 0, 8'h00, 0, mk(L, 9'h01F, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h01D));
        step("goto_1ff",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 1, 0, 2'd0, 0, 0, 1, 9'h01F));
        step("sleep",   0, 1, 3'd5, 9'h000, 0, 8'h00, 0, mk(L, 9'h020, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h020));
        for (int i = 0; i < 5; i++)
            step("slp_hold",0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(L, 9'h020, 8'h00, 0, 1, 2'd0, 0, 0, 1, 9'h020));
        step("wake",    0, 1, 3'd0, 9'h000, 0, 8'h00, 1, mk(L, 9'h020, 8'h00, 0, 1, 2'd0, 0, 0, 1, 9'h020));
        step("post_wk", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h020));
        step("wk_inc",  0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h021));
        step("sleep2",  0, 1, 3'd5, 9'h000, 0, 8'h00, 0, mk(L, 9'h022, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h022));
        step("slp2_on", 0, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(L, 9'h022, 8'h00, 0, 1, 2'd0, 0, 0, 1, 9'h022));
        step("slp_rst", 1, 1, 3'd0, 9'h000, 0, 8'h00, 0, mk(N, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 0, 9'h000));
        step("slp_off", 0, 0, 3'd0, 9'h000, 0, 8'h00, 0, mk(L, 9'h000, 8'h00, 0, 0, 2'd0, 0, 0, 1, 9'h000));
        chk("sb_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
